sata_tx_frame_arbiter: RTL and testbench

Frame-granular arbiter that shares the SATA link controller's transmit AXI-stream input (s_aixs_*) between two transport-layer requesters: requester 0 carries command/control FIS and requester 1 carries data FIS. It grants one requester per frame (SOF..EOF) and routes that requester's beats to the link with zero added latency. It enforces a maximum frame length by truncating and draining oversize frames, and inserts a configurable idle gap between frames.

---
 rtl/sata_tx_frame_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sata_tx_frame_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_tx_frame_arbiter.sv
// Frame-granular two-requester arbiter in front of the SATA link transmit stream.
// Define SATA_TX_ARB_STRICT_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module sata_tx_frame_arbiter #(
    parameter int DW         = 32,
    parameter int UW         = 8,
    parameter int MAX_BEATS  = 2049,
    parameter int GAP_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s0_axis_tdata,
    input  logic [UW-1:0] s0_axis_tuser,
    input  logic          s0_axis_tvalid,
    output logic          s0_axis_tready,
    input  logic [DW-1:0] s1_axis_tdata,
    input  logic [UW-1:0] s1_axis_tuser,
    input  logic          s1_axis_tvalid,
    output logic          s1_axis_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic [UW-1:0] m_axis_tuser,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          err_trunc,
    output logic          err_sof
);

    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BEATS - 1);
    localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;
    localparam state_t END_STATE = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t          state_reg;
    logic            owner_reg;
    logic            last_grant_reg;
    logic [1:0]      grant_reg;
    logic [BW-1:0]   beat_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic            err_trunc_reg;
    logic            err_sof_reg;

    logic [DW-1:0]   req_tdata [2];
    logic [UW-1:0]   req_tuser [2];
    logic [1:0]      req_valid;
    logic [1:0]      req_cand;
    logic [1:0]      req_bad;
    logic [1:0]      req_ready;

    logic            win_valid;
    logic            win;
    logic            disc_valid;
    logic            disc_sel;
    logic            owned;
    logic [DW-1:0]   sel_tdata;
    logic [UW-1:0]   sel_tuser;
    logic            sel_valid;
    logic            trunc_hit;
    logic            accept;
    logic [UW-1:0]   tuser_out;

    assign req_tdata[0] = s0_axis_tdata;
    assign req_tdata[1] = s1_axis_tdata;
    assign req_tuser[0] = s0_axis_tuser;
    assign req_tuser[1] = s1_axis_tuser;
    assign req_valid    = {s1_axis_tvalid, s0_axis_tvalid};

    assign owned = (state_reg == XFER) || (state_reg == DRAIN);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_cand[gi]  = req_valid[gi] & req_tuser[gi][0];
            assign req_bad[gi]   = req_valid[gi] & ~req_tuser[gi][0];
            // Owner follows the link in XFER and is unconditionally drained in DRAIN.
            assign req_ready[gi] = (owned && (owner_reg == 1'(gi)))
                                   ? ((state_reg == XFER) ? m_axis_tready : 1'b1)
                                   : (disc_valid && (disc_sel == 1'(gi)));
        end
    endgenerate

    assign s0_axis_tready = req_ready[0];
    assign s1_axis_tready = req_ready[1];

    assign win_valid = |req_cand;
`ifdef SATA_TX_ARB_STRICT_PRIO_EN
    assign win = ~req_cand[0];
`else
    assign win = (&req_cand) ? ~last_grant_reg : req_cand[1];
`endif

    // Stray mid-frame beats in IDLE are swallowed one at a time, requester 0 first.
    assign disc_valid = (state_reg == IDLE) && (|req_bad) && !rst;
    assign disc_sel   = ~req_bad[0];

    assign sel_tdata = req_tdata[owner_reg];
    assign sel_tuser = req_tuser[owner_reg];
    assign sel_valid = req_valid[owner_reg];
    assign trunc_hit = (beat_cnt_reg == BEAT_LAST);

    always_comb begin
        tuser_out = sel_tuser;
        if (state_reg == XFER && trunc_hit) begin
            tuser_out[1] = 1'b1;
        end
    end

    assign m_axis_tdata  = sel_tdata;
    assign m_axis_tuser  = tuser_out;
    assign m_axis_tvalid = (state_reg == XFER) && sel_valid;
    assign accept        = m_axis_tvalid && m_axis_tready;

    assign grant     = grant_reg;
    assign busy      = (state_reg != IDLE);
    assign err_trunc = err_trunc_reg;
    assign err_sof   = err_sof_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            grant_reg      <= 2'b00;
            beat_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            err_trunc_reg  <= 1'b0;
            err_sof_reg    <= 1'b0;
        end else begin
            err_trunc_reg <= 1'b0;
            err_sof_reg   <= disc_valid;
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        owner_reg      <= win;
                        last_grant_reg <= win;
                        grant_reg      <= win ? 2'b10 : 2'b01;
                        beat_cnt_reg   <= '0;
                        state_reg      <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        if (sel_tuser[1]) begin
                            state_reg   <= END_STATE;
                            grant_reg   <= 2'b00;
                            gap_cnt_reg <= '0;
                        end else if (trunc_hit) begin
                            err_trunc_reg <= 1'b1;
                            state_reg     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (sel_valid && sel_tuser[1]) begin
                        state_reg   <= END_STATE;
                        grant_reg   <= 2'b00;
                        gap_cnt_reg <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sata_tx_frame_arbiter.sv
// Directed bench: default-size arbiter plus a MAX_BEATS=4 copy sharing the same stimulus.
module tb_sata_tx_frame_arbiter;

    localparam int DW = 32;
    localparam int UW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] s0_tdata, s1_tdata;
    logic [UW-1:0] s0_tuser, s1_tuser;
    logic          s0_tvalid, s1_tvalid, m_tready;

    logic          s0_tready, s1_tready, m_tvalid, busy, err_trunc, err_sof;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic [1:0]    grant;

    logic          s0_tready_t, s1_tready_t, m_tvalid_t, busy_t, err_trunc_t, err_sof_t;
    logic [DW-1:0] m_tdata_t;
    logic [UW-1:0] m_tuser_t;
    logic [1:0]    grant_t;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sata_tx_frame_arbiter #(.DW(DW), .UW(UW), .MAX_BEATS(2049), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(s0_tdata), .s0_axis_tuser(s0_tuser), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
        .s1_axis_tdata(s1_tdata), .s1_axis_tuser(s1_tuser), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .grant(grant), .busy(busy), .err_trunc(err_trunc), .err_sof(err_sof)
    );

    sata_tx_frame_arbiter #(.DW(DW), .UW(UW), .MAX_BEATS(4), .GAP_CYCLES(2)) dut_t (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(s0_tdata), .s0_axis_tuser(s0_tuser), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready_t),
        .s1_axis_tdata(s1_tdata), .s1_axis_tuser(s1_tuser), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready_t),
        .m_axis_tdata(m_tdata_t), .m_axis_tuser(m_tuser_t), .m_axis_tvalid(m_tvalid_t), .m_axis_tready(m_tready),
        .grant(grant_t), .busy(busy_t), .err_trunc(err_trunc_t), .err_sof(err_sof_t)
    );

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready)
            $display("beat t=%0t grant=%b data=%h user=%h", $time, grant, m_tdata, m_tuser);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s0(input logic v, input logic [UW-1:0] u, input logic [DW-1:0] d);
        s0_tvalid = v; s0_tuser = u; s0_tdata = d;
    endtask

    task automatic set_s1(input logic v, input logic [UW-1:0] u, input logic [DW-1:0] d);
        s1_tvalid = v; s1_tuser = u; s1_tdata = d;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic       tr;
        int         b;
        int         cyc;

        set_s0(0, 0, 0);
        set_s1(0, 0, 0);
        m_tready = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        chk("rst_err_trunc", err_trunc, 0);
        chk("rst_err_sof", err_sof, 0);
        chk("rst_grant_t", grant_t, 2'b00);

        // Contention: both offer a 4-beat frame at reset release.
        set_s0(1, 8'h01, 32'hA000_0000);
        set_s1(1, 8'h01, 32'hB000_0000);
        rst = 1'b0;
        #1;
        chk("idle_s0_tready", s0_tready, 0);
        chk("idle_s1_tready", s1_tready, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_s0(1, (i == 0) ? 8'h01 : (i == 3) ? 8'h02 : 8'h00, 32'hA000_0000 + i);
            #1;
            chk("c0_grant", grant, 2'b01);
            chk("c0_m_tvalid", m_tvalid, 1);
            chk("c0_m_tdata", m_tdata, 32'hA000_0000 + i);
            chk("c0_s1_tready", s1_tready, 0);
            if (i == 3) chk("c0_eof", m_tuser, 8'h02);
            tick();
        end
        set_s0(0, 0, 0);
        #1;
        chk("c_gap1_grant", grant, 2'b00);
        chk("c_gap1_busy", busy, 1);
        chk("c_gap1_m_tvalid", m_tvalid, 0);
        tick();
        #1;
        chk("c_gap2_grant", grant, 2'b00);
        chk("c_gap2_busy", busy, 1);
        tick();
        #1;
        chk("c_idle_busy", busy, 0);
        chk("c_idle_s1_tready", s1_tready, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_s1(1, (i == 0) ? 8'h01 : (i == 3) ? 8'h02 : 8'h00, 32'hB000_0000 + i);
            #1;
            chk("c1_grant", grant, 2'b10);
            chk("c1_m_tdata", m_tdata, 32'hB000_0000 + i);
            chk("c1_s0_tready", s0_tready, 0);
            tick();
        end
        set_s1(0, 0, 0);
        tick();
        tick();
        #1;
        chk("c_end_busy", busy, 0);

        // Round-robin: both continuously offer single-beat frames.
        set_s0(1, 8'h03, 32'h0000_00C0);
        set_s1(1, 8'h03, 32'h0000_01C0);
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
`ifdef SATA_TX_ARB_STRICT_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk("rr_grant", grant, exp_g);
            chk("rr_m_tvalid", m_tvalid, 1);
            chk("rr_m_tdata", m_tdata, (exp_g == 2'b01) ? 32'h0000_00C0 : 32'h0000_01C0);
            tick();
            if (i == 9) begin
                set_s0(0, 0, 0);
                set_s1(0, 0, 0);
            end
            tick();
            tick();
        end

        // Backpressure: link ready toggles during a 5-beat s1 frame.
        set_s1(1, 8'h01, 32'hC000_0000);
        tick();
        b = 0;
        cyc = 0;
        tr = 1'b1;
        while (b < 5 && cyc < 20) begin
            set_s1(1, (b == 0) ? 8'h01 : (b == 4) ? 8'h02 : 8'h00, 32'hC000_0000 + b);
            m_tready = tr;
            #1;
            chk("bp_m_tdata", m_tdata, 32'hC000_0000 + b);
            chk("bp_s0_tready", s0_tready, 0);
            chk("bp_s1_tready", s1_tready, tr);
            tick();
            if (tr) b++;
            tr = ~tr;
            cyc++;
        end
        chk("bp_beats", b, 5);
        chk("bp_cycles", cyc, 9);
        set_s1(0, 0, 0);
        m_tready = 1'b1;
        #1;
        chk("bp_gap_grant", grant, 2'b00);
        chk("bp_gap_busy", busy, 1);
        tick();
        tick();

        // Non-SOF beat in IDLE is discarded with an error pulse.
        set_s1(1, 8'h00, 32'h0000_DEAD);
        #1;
        chk("sof_s1_tready", s1_tready, 1);
        chk("sof_s0_tready", s0_tready, 0);
        chk("sof_err_before", err_sof, 0);
        tick();
        set_s1(0, 0, 0);
        #1;
        chk("sof_err_pulse", err_sof, 1);
        chk("sof_s1_tready_off", s1_tready, 0);
        chk("sof_busy", busy, 0);
        tick();
        #1;
        chk("sof_err_clear", err_sof, 0);

        // Reset on beat 2 of an s0 frame.
        set_s0(1, 8'h01, 32'hE000_0000);
        tick();
        #1;
        chk("rm_beat1", m_tdata, 32'hE000_0000);
        tick();
        set_s0(1, 8'h00, 32'hE000_0001);
        rst = 1'b1;
        #1;
        chk("rm_beat2", m_tdata, 32'hE000_0001);
        tick();
        rst = 1'b0;
        set_s0(0, 0, 0);
        #1;
        chk("rm_grant", grant, 2'b00);
        chk("rm_m_tvalid", m_tvalid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_grant_t", grant_t, 2'b00);
        chk("rm_busy_t", busy_t, 0);

        // Truncation: 7-beat s0 frame into the MAX_BEATS=4 copy.
        set_s0(1, 8'h01, 32'hF000_0000);
        tick();
        for (int i = 0; i < 7; i++) begin
            set_s0(1, (i == 0) ? 8'h01 : (i == 6) ? 8'h02 : 8'h00, 32'hF000_0000 + i);
            #1;
            chk("tr_full_m_tvalid", m_tvalid, 1);
            chk("tr_full_m_tdata", m_tdata, 32'hF000_0000 + i);
            chk("tr_full_eof", m_tuser[1], (i == 6));
            chk("tr_m_tvalid_t", m_tvalid_t, (i < 4));
            if (i < 4) begin
                chk("tr_m_tdata_t", m_tdata_t, 32'hF000_0000 + i);
                chk("tr_eof_t", m_tuser_t[1], (i == 3));
            end
            chk("tr_s0_tready_t", s0_tready_t, 1);
            chk("tr_err_trunc_t", err_trunc_t, (i == 4));
            chk("tr_grant_t", grant_t, 2'b01);
            chk("tr_full_err_trunc", err_trunc, 0);
            tick();
        end
        set_s0(0, 0, 0);
        #1;
        chk("tr_gap_busy_t", busy_t, 1);
        chk("tr_gap_grant_t", grant_t, 2'b00);
        chk("tr_gap_err_t", err_trunc_t, 0);
        chk("tr_gap_grant", grant, 2'b00);
        chk("tr_gap_busy", busy, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
